// File: rtl/alu_result_packer_if.sv
// rtl/alu_result_packer_if.sv - ALU result input and TX FIFO write-port bundle for alu_result_packer
//
// Signals:
//   ALU_OUT        ALU result word (RES_WIDTH)
//   ALU_OUT_VALID  ALU result valid, level
//   FIFO_FULL      downstream FIFO full
//   WR_DATA        byte written to the FIFO (DATA_WIDTH)
//   WR_INC         one-cycle FIFO write strobe
// Modports:
//   master  packer side: drives WR_DATA/WR_INC, receives ALU result and FIFO_FULL
//   slave   environment side: drives ALU result and FIFO_FULL, receives WR_DATA/WR_INC
interface alu_result_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH
);
    logic [RES_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VALID;
    logic                  FIFO_FULL;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_INC;

    modport master (
        input  ALU_OUT,
        input  ALU_OUT_VALID,
        input  FIFO_FULL,
        output WR_DATA,
        output WR_INC
    );

    modport slave (
        output ALU_OUT,
        output ALU_OUT_VALID,
        output FIFO_FULL,
        input  WR_DATA,
        input  WR_INC
    );
endinterface

// File: rtl/alu_result_packer.sv
// rtl/alu_result_packer.sv - buffers ALU results and serializes them LSB-first into the TX FIFO write port
//
// Optional feature macro: ALU_PKR_HDR_EN (prefixes every result with HDR_BYTE).
//
// Ports:
//   ALU_CLK     in   clock, rising edge
//   RST_SYNC_2  in   synchronous active-low reset
//   bus         if   alu_result_packer_if.master: ALU_OUT, ALU_OUT_VALID, FIFO_FULL in;
//                    WR_DATA, WR_INC out (both registered)
//   OVF_CLR     in   clears the sticky overflow flag
//   BUSY        out  buffer holds at least one result
//   BUF_CNT     out  number of buffered results
//   OVF         out  sticky: a result was dropped because the buffer was full
module alu_result_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH,
    parameter int BUF_DEPTH  = 2
`ifdef ALU_PKR_HDR_EN
    ,
    parameter logic [DATA_WIDTH-1:0] HDR_BYTE = 8'hA5
`endif
) (
    input  logic                         ALU_CLK,
    input  logic                         RST_SYNC_2,
    alu_result_packer_if.master          bus,
    input  logic                         OVF_CLR,
    output logic                         BUSY,
    output logic [$clog2(BUF_DEPTH):0]   BUF_CNT,
    output logic                         OVF
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // State names the next byte to issue for the head result.
`ifdef ALU_PKR_HDR_EN
    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_LSB = 2'd1,
        S_MSB = 2'd2
    } state_t;
    localparam state_t S_START = S_HDR;
`else
    typedef enum logic {
        S_LSB = 1'b0,
        S_MSB = 1'b1
    } state_t;
    localparam state_t S_START = S_LSB;
`endif

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_valid_d;
    logic [RES_WIDTH-1:0]  r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ovf;
    logic                  r_wr_inc;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_not_empty;
    logic                  w_accept;
    logic                  w_drop;
    logic [RES_WIDTH-1:0]  w_head;
    logic                  w_wr_inc_nxt;
    logic [DATA_WIDTH-1:0] w_wr_data_nxt;

    // One capture per rising edge of the level valid.
    assign w_push      = bus.ALU_OUT_VALID & ~r_valid_d;
    assign w_full      = (r_cnt == CNT_W'(BUF_DEPTH));
    assign w_not_empty = (r_cnt != '0);
    // A pop frees the head slot at the same edge, so a push into a full buffer
    // is still accepted; when full the write slot is the one being popped,
    // and the popped value is read before the write lands.
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_head      = r_buf[r_rd_ptr];

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_inc_nxt  = 1'b0;
        w_wr_data_nxt = r_wr_data;
        w_pop         = 1'b0;
        case (r_state)
`ifdef ALU_PKR_HDR_EN
            S_HDR: begin
                if (w_not_empty && !bus.FIFO_FULL) begin
                    w_wr_inc_nxt  = 1'b1;
                    w_wr_data_nxt = HDR_BYTE;
                    w_state_nxt   = S_LSB;
                end
            end
`endif
            S_LSB: begin
                if (w_not_empty && !bus.FIFO_FULL) begin
                    w_wr_inc_nxt  = 1'b1;
                    w_wr_data_nxt = w_head[DATA_WIDTH-1:0];
                    w_state_nxt   = S_MSB;
                end
            end
            S_MSB: begin
                // Only reachable with a head entry present.
                if (!bus.FIFO_FULL) begin
                    w_wr_inc_nxt  = 1'b1;
                    w_wr_data_nxt = w_head[RES_WIDTH-1:DATA_WIDTH];
                    w_pop         = 1'b1;
                    w_state_nxt   = S_START;
                end
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    always_ff @(posedge ALU_CLK) begin
        if (!RST_SYNC_2) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ALU_CLK) begin
        if (!RST_SYNC_2) begin
            r_wr_inc  <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_inc  <= w_wr_inc_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    always_ff @(posedge ALU_CLK) begin
        if (!RST_SYNC_2) begin
            r_valid_d <= 1'b0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            r_valid_d <= bus.ALU_OUT_VALID;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_accept) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge ALU_CLK) begin
        if (RST_SYNC_2 && w_accept) begin
            r_buf[r_wr_ptr] <= bus.ALU_OUT;
        end
    end

    // A drop in the same cycle as OVF_CLR wins.
    always_ff @(posedge ALU_CLK) begin
        if (!RST_SYNC_2) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (OVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.WR_INC  = r_wr_inc;
    assign bus.WR_DATA = r_wr_data;
    assign BUSY        = w_not_empty;
    assign BUF_CNT     = r_cnt;
    assign OVF         = r_ovf;

endmodule

// File: doc/alu_result_packer.md
Name: alu_result_packer

Overview:
- Downstream neighbour of the ALU stage, in the same clock domain.
- Captures each new 16-bit ALU result on the rising edge of ALU_OUT_VALID and holds it in a small in-order buffer.
- Serializes each result into bytes, LSB first then MSB, and writes them into the TX-path FIFO write port, throttled by FIFO_FULL.
- Flags dropped results with a sticky overflow bit.

Parameters:
- RES_WIDTH, 16, width of ALU result input; fixed at 2*DATA_WIDTH.
- DATA_WIDTH, 8, byte width on FIFO write port.
- BUF_DEPTH, 2, result buffer entries; power of two, >=2.
- HDR_BYTE, 8'hA5, header byte value; used only when ALU_PKR_HDR_EN is defined.

Ports:
- ALU_CLK  in  1  clock, rising edge.
- RST_SYNC_2  in  1  reset, synchronous, active-low.
- ALU_OUT  in  RES_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid (level; may stay high many cycles).
- FIFO_FULL  in  1  downstream FIFO full; no write may be issued while high.
- WR_DATA  out  DATA_WIDTH  byte to FIFO, registered.
- WR_INC  out  1  one-cycle write strobe per byte, registered.
- BUSY  out  1  high while buffer count != 0.
- BUF_CNT  out  $clog2(BUF_DEPTH)+1  buffered result count.
- OVF  out  1  sticky: a result was dropped.
- OVF_CLR  in  1  clears OVF.

Behaviour:
- Reset is the only reset; it is sampled on the rising edge of ALU_CLK.
- Reset values: WR_DATA=0, WR_INC=0, BUSY=0, BUF_CNT=0, OVF=0, FSM=S_LSB, valid_d=0. Buffer storage is don't-care.
- Reset mid-operation: a partially sent result and all buffered results are discarded. No WR_INC is issued in the cycle after reset.
- Capture:
  - valid_d registers ALU_OUT_VALID.
  - push = ALU_OUT_VALID & ~valid_d. Exactly one capture per 0->1 transition, regardless of how long valid stays high.
  - ALU_OUT is sampled at the push edge.
- Buffer is circular FIFO of BUF_DEPTH entries, with wrapping read/write pointers and strict order.
  - Push when full with no pop at the same edge: result dropped, OVF<=1, contents unchanged.
  - Push and pop at the same edge: always accepted, including when full; BUF_CNT unchanged.
- FSM (state = next byte to issue), with states S_LSB and S_MSB:
  - S_LSB: if BUF_CNT>0 and FIFO_FULL==0, then WR_INC<=1, WR_DATA<=head[7:0], go S_MSB.
  - S_MSB: if FIFO_FULL==0, then WR_INC<=1, WR_DATA<=head[15:8], pop head. Go S_LSB.
  - In either state, if FIFO_FULL==1: WR_INC<=0, WR_DATA holds, state holds.
  - Otherwise WR_INC<=0.
- Latency: push at edge E0 -> LSB strobe registered at E1, MSB at E2, next result's LSB at E3. Sustained rate is 1 byte/cycle.
- FIFO_FULL is sampled at the issuing edge. The FIFO must deassert full only when it has room for the byte.
- Head entry is stable from push until pop, independent of later ALU_OUT changes.
- OVF priority: a set event overrides OVF_CLR in the same cycle; otherwise OVF_CLR clears OVF at the next edge.
- BUSY = (BUF_CNT != 0). It goes low at the same edge as the last pop.

Optional Feature:
- Macro: ALU_PKR_HDR_EN.
- Defined:
  - Adds state S_HDR, which is the reset state. S_HDR issues HDR_BYTE under the same BUF_CNT>0 / FIFO_FULL rules, then goes S_LSB.
  - S_MSB returns to S_HDR. Each result is 3 bytes: HDR, LSB, MSB. Latency: HDR at E1, LSB at E2, MSB at E3.
- Not defined: no S_HDR, 2 bytes per result; HDR_BYTE is unused.

Test Plan:
- Single result: ALU_OUT=16'h1234, valid high 1 cycle, FIFO_FULL=0 -> WR_INC pulses at E1 (WR_DATA=8'h34) and E2 (8'h12). BUSY low after E2. OVF=0.
- Level valid: valid held high 6 cycles with ALU_OUT=16'hBEEF -> exactly two WR_INC pulses (8'hEF, 8'hBE), BUF_CNT never exceeds 1.
- Stall: result 16'hA1B2; FIFO_FULL=1 from after the LSB until 4 cycles later -> 8'hB2 sent, WR_INC low 4 cycles, 8'hA1 sent at first edge with FIFO_FULL=0.
- Overflow, BUF_DEPTH=2, FIFO_FULL=1: results 16'h0001, 16'h0002, 16'h0003 -> OVF=1, BUF_CNT=2. Release full -> bytes 01,00,02,00 only.
- OVF_CLR pulsed on the same edge as a new drop -> OVF stays 1. OVF_CLR alone the next cycle -> OVF=0.
- Reset asserted in S_MSB with 2 buffered results -> after reset: WR_INC=0, BUF_CNT=0, OVF=0. New result 16'h5566 -> 8'h66 then 8'h55. With ALU_PKR_HDR_EN defined, the sequence is 8'hA5, 8'h66, 8'h55.
